// File: rtl/pdm_cic_decim_pkg.sv
// pdm_pkg: shared widths, saturation limits and CIC sizing helpers for the PDM front end
package pdm_pkg;
  localparam int OUT_W = 18;
  localparam int CIC_ORDER = 3;
  localparam int SAT_MAX = 131071;
  localparam int SAT_MIN = -131072;
  typedef logic signed [OUT_W-1:0] sample_t;
  function automatic int cic_w(int decim);
    return CIC_ORDER * $clog2(decim) + 2;
  endfunction
  function automatic int cic_sh(int decim);
    return CIC_ORDER * $clog2(decim) + 1 - OUT_W;
  endfunction
endpackage

// File: rtl/pdm_cic_decim_if.sv
// pdm_cic_decim_if: microphone pins, run control and audio sample output
// master (front end): in ENABLE, PDM_DAT; out PDM_CLK, ADATA0, ADATARDY
// slave (mic + analysis side): the mirror image
interface pdm_cic_decim_if;
  import pdm_pkg::*;
  logic ENABLE;
  logic PDM_CLK;
  logic PDM_DAT;
  logic [OUT_W-1:0] ADATA0;
  logic ADATARDY;
  modport master(input ENABLE, PDM_DAT, output PDM_CLK, ADATA0, ADATARDY);
  modport slave(output ENABLE, PDM_DAT, input PDM_CLK, ADATA0, ADATARDY);
endinterface

// File: rtl/pdm_cic_decim_clkgen.sv
// pdm_clkgen: PDM bit clock divider, data synchronizer and sample strobe
// in: CLK, nRST (sync, active-low), en (low = clear), pdm_dat (async mic data)
// out: pdm_clk (mic clock), s_stb (one-cycle sample strobe), s_bit (synchronized bit)
module pdm_clkgen #(
  parameter int CLK_DIV = 30,
  parameter bit SAMPLE_EDGE = 1'b1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic pdm_dat,
  output logic pdm_clk,
  output logic s_stb,
  output logic s_bit
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] STB_AT = CW'(SAMPLE_EDGE ? CLK_DIV - 1 : HALF - 1);
  logic [CW-1:0] div_cnt;
  logic [1:0] sync;
  always_ff @(posedge CLK)
    if (!nRST || !en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
      sync <= '0;
    end else begin
      div_cnt <= div_cnt == CW'(CLK_DIV - 1) ? '0 : div_cnt + 1'b1;
      pdm_clk <= div_cnt < CW'(HALF);
      sync <= {sync[0], pdm_dat};
    end
  assign s_stb = en && div_cnt == STB_AT;
  assign s_bit = sync[1];
endmodule

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: PDM mic clocking, 3rd-order CIC decimation and 18-bit sample output
// in: CLK, nRST (sync, active-low); bus.ENABLE (low = soft clear), bus.PDM_DAT
// out: bus.PDM_CLK, bus.ADATA0 (signed, held), bus.ADATARDY (one-cycle strobe)
module pdm_cic_decim
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 30,
  parameter int DECIM = 64,
  parameter bit SAMPLE_EDGE = 1'b1
) (
  input logic CLK,
  input logic nRST,
  pdm_cic_decim_if.master bus
);
  localparam int W = cic_w(DECIM);
  localparam int SH = cic_sh(DECIM);
  localparam int DW = $clog2(DECIM);
  localparam logic signed [W-1:0] HI = W'(SAT_MAX);
  localparam logic signed [W-1:0] LO = W'(SAT_MIN);
  logic clr, s_stb, s_bit, dec, rdy_n;
  logic [DW-1:0] dec_cnt;
  logic [1:0] warm;
  logic [CIC_ORDER-1:0] v, cvin;
  logic signed [W-1:0] x, sc;
  logic signed [W-1:0] integ [CIC_ORDER];
  logic signed [W-1:0] dly [CIC_ORDER];
  logic signed [W-1:0] y [CIC_ORDER];
  logic signed [W-1:0] cin [CIC_ORDER];
  logic [OUT_W-1:0] sat;
  pdm_clkgen #(.CLK_DIV(CLK_DIV), .SAMPLE_EDGE(SAMPLE_EDGE)) u_clkgen (
    .CLK(CLK),
    .nRST(nRST),
    .en(bus.ENABLE),
    .pdm_dat(bus.PDM_DAT),
    .pdm_clk(bus.PDM_CLK),
    .s_stb(s_stb),
    .s_bit(s_bit)
  );
  assign clr = !nRST || !bus.ENABLE;
  assign x = s_bit ? W'(1) : '1;
  assign dec = s_stb && &dec_cnt;
  // comb stage k takes its input one cycle after stage k-1 produced it
  assign cvin = {v[CIC_ORDER-2:0], dec};
  always_comb begin
    cin[0] = integ[CIC_ORDER-1];
    for (int k = 1; k < CIC_ORDER; k++) cin[k] = y[k-1];
  end
  // the first three decimated results still carry start-up transients
  assign rdy_n = v[CIC_ORDER-1] && warm == 2'd3;
  assign sc = y[CIC_ORDER-1] >>> SH;
  assign sat = sc > HI ? OUT_W'(SAT_MAX) : sc < LO ? OUT_W'(SAT_MIN) : sc[OUT_W-1:0];
  always_ff @(posedge CLK)
    if (clr) begin
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ[k] <= '0;
        dly[k] <= '0;
        y[k] <= '0;
      end
      dec_cnt <= '0;
      v <= '0;
      warm <= '0;
      bus.ADATARDY <= 1'b0;
    end else begin
      if (s_stb) begin
        integ[0] <= integ[0] + x;
        for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        dec_cnt <= dec_cnt + 1'b1;
      end
      for (int k = 0; k < CIC_ORDER; k++)
        if (cvin[k]) begin
          y[k] <= cin[k] - dly[k];
          dly[k] <= cin[k];
        end
      v <= cvin;
      if (v[CIC_ORDER-1] && warm != 2'd3) warm <= warm + 1'b1;
      bus.ADATARDY <= rdy_n;
    end
  // the sample survives a soft clear; only reset zeroes it
  always_ff @(posedge CLK)
    if (!nRST) bus.ADATA0 <= '0;
    else if (bus.ENABLE && rdy_n) bus.ADATA0 <= sat;
endmodule
